// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one full-adder cell processes
// one bit per clock, LSB first, with a registered carry between bits.

module FULL_ADDER (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SnA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Y,
    output logic             CO,
    output logic             V,
    output logic             BUSY,
    output logic             DONE
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    logic [WIDTH-1:0]   s_sh_q;
    logic [WIDTH-1:0]   s_sh_d;
    logic               c_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   y_q;
    logic               co_q;
    logic               v_q;
    logic               busy_q;
    logic               done_q;
    logic               fa_sum;
    logic               fa_carry;
    logic               last_bit;

    FULL_ADDER u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (c_q),
        .s_o (fa_sum),
        .c_o (fa_carry)
    );

    assign s_sh_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            y_q     <= '0;
            co_q    <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        // Subtraction is A + ~B + 1: invert B, seed the carry.
                        a_sh_q  <= A;
                        b_sh_q  <= SnA ? ~B : B;
                        c_q     <= SnA;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
                    s_sh_q <= s_sh_d;
                    c_q    <= fa_carry;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_bit) begin
                        // c_q here is the carry into the MSB.
                        y_q     <= s_sh_d;
                        co_q    <= fa_carry;
                        v_q     <= c_q ^ fa_carry;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign Y    = y_q;
    assign CO   = co_q;
    assign V    = v_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: the driver queues expected results,
// a negedge monitor checks each DONE pulse for value and latency.

module tb_serial_add_sub;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         START = 1'b0;
    logic         SnA = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic [W-1:0] Y;
    logic         CO, V, BUSY, DONE;

    typedef struct {
        logic [W-1:0] y;
        logic         co;
        logic         v;
        int           cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sna;
        logic [W-1:0] y;
        logic         co;
        logic         v;
    } vec_t;

    exp_t         sb_q[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic [W+1:0] prev_res = '0;

    serial_add_sub #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .SnA   (SnA),
        .A     (A),
        .B     (B),
        .Y     (Y),
        .CO    (CO),
        .V     (V),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioral reference for the random regression.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sna);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] r;
        r    = sna ? a - b : a + b;
        full = sna ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        e.y  = r;
        e.co = sna ? (a >= b) : full[W];
        e.v  = sna ? (a[W-1] != b[W-1]) && (r[W-1] != a[W-1])
                   : (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
        e.cyc = 0;
        return e;
    endfunction

    // Called at a negedge; START is sampled at the following posedge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sna,
                            input bit push, input logic [W-1:0] ey, input logic eco, input logic ev);
        exp_t e;
        A = a; B = b; SnA = sna; START = 1'b1;
        if (push) begin
            e.y = ey; e.co = eco; e.v = ev; e.cyc = cyc + 1 + W;
            sb_q.push_back(e);
        end
        @(negedge CLK);
        START = 1'b0;
        A = $urandom; B = $urandom; SnA = 1'($urandom);
    endtask

    // Leaves the bench at the negedge where BUSY has dropped (DUT in DONE).
    task automatic wait_done();
        int n = 0;
        while (BUSY && n < 4 * W) begin
            @(negedge CLK);
            n++;
        end
        check("busy_timeout", 64'(BUSY), 64'd0);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            prev_res = '0;
        end else begin
            if (BUSY) check("hold_during_run", 64'({Y, CO, V}), 64'(prev_res));
            if (DONE) begin
                check("busy_done_overlap", 64'(BUSY), 64'd0);
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result_y", 64'(Y), 64'(e.y));
                    check("result_co", 64'(CO), 64'(e.co));
                    check("result_v", 64'(V), 64'(e.v));
                    check("done_latency", 64'(cyc), 64'(e.cyc));
                    prev_res = {e.y, e.co, e.v};
                end
            end
        end
    end

    vec_t vecs[8] = '{
        '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0},
        '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
        '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
        '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
        '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
        '{32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0}
    };

    initial begin
        exp_t         e;
        logic [W-1:0] ra, rb;
        logic         rs;
        int           n;

        repeat (3) @(negedge CLK);
        check("reset_y", 64'(Y), 64'd0);
        check("reset_flags", 64'({CO, V, BUSY, DONE}), 64'd0);
        RST = 1'b1;
        @(negedge CLK);

        // Directed vectors; the last two run back-to-back through DONE.
        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sna, 1'b1, vecs[i].y, vecs[i].co, vecs[i].v);
            wait_done();
            if (i < 6) @(negedge CLK);
        end
        @(negedge CLK);

        // START pulsed at RUN cycle 4 with different operands must be ignored.
        start_op(32'h0000_1234, 32'h0000_0034, 1'b1, 1'b1, 32'h0000_1200, 1'b1, 1'b0);
        repeat (3) @(negedge CLK);
        A = 32'hDEAD_BEEF; B = 32'h1111_1111; SnA = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done();
        @(negedge CLK);

        // Reset in the middle of RUN: outputs clear at once, no DONE follows.
        start_op(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        repeat (9) @(negedge CLK);
        #1 RST = 1'b0;
        #1;
        check("async_reset_y", 64'(Y), 64'd0);
        check("async_reset_flags", 64'({CO, V, BUSY, DONE}), 64'd0);
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        start_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
        wait_done();

        // Random regression against the behavioral model.
        for (int k = 0; k < 1000; k++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom);
            if ($urandom_range(0, 3) == 0) @(negedge CLK);
            e = model(ra, rb, rs);
            start_op(ra, rb, rs, 1'b1, e.y, e.co, e.v);
            wait_done();
        end

        n = 0;
        while (sb_q.size() != 0 && n < 4 * W) begin
            @(negedge CLK);
            n++;
        end
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        repeat (4) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
